// File: rtl/femto_clock_enables_if.sv
// Configuration and output bundle for femto_clock_enables.
// The master side writes channel config, and the slave side (the generator) drives the enables.
interface femto_clock_enables_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_SEL_W = 2,
  parameter int unsigned ACC_W    = 24
);
  logic                cfg_we;
  logic [CH_SEL_W-1:0] cfg_ch;
  logic [ACC_W-1:0]    cfg_inc;
  logic                cfg_mode;
  logic                locked;
  logic [NUM_CH-1:0]   tick;
  logic [NUM_CH-1:0]   sq;

  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_mode,
    input  locked, tick, sq
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_mode,
    output locked, tick, sq
  );
endinterface

// File: rtl/femto_clock_enables.sv
// Multi-channel NCO clock-enable generator with a startup settle sequencer.
// Each channel emits a tick on phase accumulator overflow and can optionally output its MSB as a square wave.
module femto_clock_enables #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_SEL_W    = 2,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  femto_clock_enables_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {SETTLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic              wr_valid;

  assign wr_valid = bus.cfg_we && (32'(bus.cfg_ch) < NUM_CH);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    mode_d   = mode_q;
    tick_d   = '0;
    sq_d     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
    end

    unique case (state_q)
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RUN;
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) acc_d[i] = '0;
      end
      RUN: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          acc_d[i]  = sum[i][ACC_W-1:0];
          tick_d[i] = sum[i][ACC_W];
          sq_d[i]   = mode_q[i] & sum[i][ACC_W-1];
        end
      end
      default: state_d = SETTLE;
    endcase

    // A config write overrides the accumulate step, so the channel restarts its phase from zero.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_valid && bus.cfg_ch == CH_SEL_W'(i)) begin
        inc_d[i]  = bus.cfg_inc;
        mode_d[i] = bus.cfg_mode;
        acc_d[i]  = '0;
        tick_d[i] = 1'b0;
        sq_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      mode_q   <= '0;
      tick_q   <= '0;
      sq_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign bus.locked = locked_q;
  assign bus.tick   = tick_q;
  assign bus.sq     = sq_q;

endmodule
